// File: rtl/fft_twiddle_sequencer.sv
`timescale 1ns/1ps
// Radix-2 DIT FFT address/twiddle sequencer: walks stages and butterflies,
// issues one descriptor per cycle over valid/ready, and holds a stage barrier
// until the datapath reports write-back of the current stage has retired.
module fft_twiddle_sequencer #(
    parameter int unsigned LOG2N  = 12,
    parameter int unsigned ROM_AW = 12,
    parameter int unsigned STW    = $clog2(LOG2N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stage_done,
    output logic              bf_valid,
    input  logic              bf_ready,
    output logic [LOG2N-1:0]  bf_idx_a,
    output logic [LOG2N-1:0]  bf_idx_b,
    output logic [ROM_AW-1:0] tw_addr,
    output logic [STW-1:0]    bf_stage,
    output logic              bf_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW    = LOG2N - 1;
    localparam int unsigned TW_SH = ROM_AW - LOG2N;
    localparam logic [CW-1:0]  C_LAST = '1;
    localparam logic [STW-1:0] S_LAST = STW'(LOG2N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state, state_n;
    logic [STW-1:0]    stage, stage_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              done_n;
    logic              last_n;
    logic [LOG2N-1:0]  c_w, half, k, g, e, a_n, b_n;
    logic [STW-1:0]    shamt;
    logic [ROM_AW-1:0] tw_n;

    // Next state, stage/counter advance, and the descriptor for the next cycle
    always_comb begin
        state_n = state;
        stage_n = stage;
        cnt_n   = cnt;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = ISSUE;
                    stage_n = '0;
                    cnt_n   = '0;
                end
            end
            ISSUE: begin
                if (bf_ready) begin
                    if (cnt == C_LAST) begin
                        state_n = WAIT;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            WAIT: begin
                if (stage_done) begin
                    cnt_n = '0;
                    if (stage == S_LAST) begin
                        state_n = IDLE;
                        stage_n = '0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ISSUE;
                        stage_n = stage + STW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                stage_n = '0;
                cnt_n   = '0;
            end
        endcase

        // Operand a inserts a zero at bit 'stage' of the counter; b sets it.
        c_w   = LOG2N'(cnt_n);
        half  = LOG2N'(1) << stage_n;
        k     = c_w & (half - LOG2N'(1));
        g     = c_w >> stage_n;
        a_n   = ((g << stage_n) << 1) | k;
        b_n   = a_n + half;
        shamt = S_LAST - stage_n;
        e     = k << shamt;
        tw_n  = ROM_AW'(e) << TW_SH;
        last_n = (state_n == ISSUE) && (cnt_n == C_LAST);
    end

    // State and registered outputs; outputs hold while a stalled descriptor waits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            stage    <= '0;
            cnt      <= '0;
            bf_valid <= 1'b0;
            bf_idx_a <= '0;
            bf_idx_b <= '0;
            tw_addr  <= '0;
            bf_stage <= '0;
            bf_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            stage    <= stage_n;
            cnt      <= cnt_n;
            bf_valid <= (state_n == ISSUE);
            bf_idx_a <= a_n;
            bf_idx_b <= b_n;
            tw_addr  <= tw_n;
            bf_stage <= stage_n;
            bf_last  <= last_n;
            busy     <= (state_n != IDLE);
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
`timescale 1ns/1ps
// Bench for fft_twiddle_sequencer: a LOG2N=3 instance for directed scenarios
// and a LOG2N=12 instance for a full-size transform, both scoreboarded.
module tb_fft_twiddle_sequencer;

    localparam int unsigned SL = 3;
    localparam int unsigned BL = 12;
    localparam int unsigned RA = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          s_start, s_sd, s_ready, s_valid, s_last, s_busy, s_done;
    logic [SL-1:0] s_a, s_b;
    logic [RA-1:0] s_tw;
    logic [1:0]    s_stage;

    logic          b_start, b_sd, b_ready, b_valid, b_last, b_busy, b_done;
    logic [BL-1:0] b_a, b_b;
    logic [RA-1:0] b_tw;
    logic [3:0]    b_stage;

    fft_twiddle_sequencer #(.LOG2N(SL), .ROM_AW(RA)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .stage_done(s_sd),
        .bf_valid(s_valid), .bf_ready(s_ready), .bf_idx_a(s_a), .bf_idx_b(s_b),
        .tw_addr(s_tw), .bf_stage(s_stage), .bf_last(s_last), .busy(s_busy),
        .done(s_done)
    );

    fft_twiddle_sequencer #(.LOG2N(BL), .ROM_AW(RA)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .stage_done(b_sd),
        .bf_valid(b_valid), .bf_ready(b_ready), .bf_idx_a(b_a), .bf_idx_b(b_b),
        .tw_addr(b_tw), .bf_stage(b_stage), .bf_last(b_last), .busy(b_busy),
        .done(b_done)
    );

    typedef struct {
        int a;
        int b;
        int tw;
        int st;
        int last;
    } desc_t;

    desc_t q_s[$];
    desc_t q_b[$];

    int n_vec = 0;
    int n_err = 0;
    int s_done_cnt = 0;
    int b_done_cnt = 0;
    int s_busy_cyc = 0;
    bit bp_en = 1'b0;
    int b_last_a = 0;
    int b_last_b = 0;
    int b_last_tw = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference table for the 8-point transform
    task automatic push_small();
        int ta[12];
        int tb[12];
        int tt[12];
        desc_t d;
        ta = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        tb = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        tt = '{0, 0, 0, 0, 0, 1024, 0, 1024, 0, 512, 1024, 1536};
        for (int i = 0; i < 12; i++) begin
            d.a = ta[i]; d.b = tb[i]; d.tw = tt[i];
            d.st = i / 4; d.last = (i % 4 == 3) ? 1 : 0;
            q_s.push_back(d);
        end
    endtask

    // Reference model for the 4096-point transform
    task automatic push_big();
        desc_t d;
        int half, low, high;
        for (int s = 0; s < int'(BL); s++) begin
            for (int c = 0; c < 2048; c++) begin
                half = 1 << s;
                low  = c % half;
                high = c / half;
                d.a  = high * 2 * half + low;
                d.b  = d.a + half;
                d.tw = low * (4096 / (2 * half)) * (1 << (RA - BL));
                d.st = s;
                d.last = (c == 2047) ? 1 : 0;
                q_b.push_back(d);
            end
        end
    endtask

    logic        s_hold = 1'b0;
    logic [31:0] s_snap = '0;
    desc_t       es, eb;

    // Small-instance monitor: transfers, stall stability, done pulses
    always @(negedge clk) begin
        if (rst) begin
            s_hold = 1'b0;
        end else begin
            if (s_hold)
                chk("s_stall_stable",
                    32'({s_valid, s_a, s_b, s_tw, s_stage, s_last}), s_snap);
            if (s_valid && s_ready) begin
                chk("s_q_nonempty", 32'(q_s.size() != 0), 32'(1));
                if (q_s.size() != 0) begin
                    es = q_s.pop_front();
                    chk("s_idx_a", 32'(s_a), es.a);
                    chk("s_idx_b", 32'(s_b), es.b);
                    chk("s_tw", 32'(s_tw), es.tw);
                    chk("s_stage", 32'(s_stage), es.st);
                    chk("s_last", 32'(s_last), es.last);
                end
            end
            s_hold = s_valid && !s_ready;
            s_snap = 32'({s_valid, s_a, s_b, s_tw, s_stage, s_last});
            if (s_busy === 1'b1) s_busy_cyc++;
        end
        if (s_done === 1'b1) s_done_cnt++;
    end

    // Large-instance monitor
    always @(negedge clk) begin
        if (!rst && b_valid && b_ready) begin
            chk("b_q_nonempty", 32'(q_b.size() != 0), 32'(1));
            if (q_b.size() != 0) begin
                eb = q_b.pop_front();
                chk("b_idx_a", 32'(b_a), eb.a);
                chk("b_idx_b", 32'(b_b), eb.b);
                chk("b_tw", 32'(b_tw), eb.tw);
                chk("b_stage", 32'(b_stage), eb.st);
                chk("b_last", 32'(b_last), eb.last);
            end
            b_last_a  = int'(b_a);
            b_last_b  = int'(b_b);
            b_last_tw = int'(b_tw);
        end
        if (b_done === 1'b1) b_done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_en) s_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [31:0] get_valid(input int sel);
        return (sel == 0) ? 32'(s_valid) : 32'(b_valid);
    endfunction
    function automatic logic [31:0] get_busy(input int sel);
        return (sel == 0) ? 32'(s_busy) : 32'(b_busy);
    endfunction
    function automatic logic [31:0] get_done(input int sel);
        return (sel == 0) ? 32'(s_done) : 32'(b_done);
    endfunction
    function automatic logic [31:0] get_stage(input int sel);
        return (sel == 0) ? 32'(s_stage) : 32'(b_stage);
    endfunction

    task automatic set_sd(input int sel, input logic v);
        if (sel == 0) s_sd = v;
        else b_sd = v;
    endtask

    // For each of nst stages: wait for the barrier, optionally hold it, then release
    task automatic run_stages(input int sel, input int nst, input int total,
                              input int hold, input int bound);
        int i;
        for (int s = 0; s < nst; s++) begin
            i = 0;
            while (!(get_valid(sel) == 0 && get_busy(sel) == 1) && i < bound) begin
                tick();
                i++;
            end
            chk("wait_reached", 32'(i < bound), 32'(1));
            if (i >= bound) return;
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("barrier_valid", get_valid(sel), 32'(0));
                chk("barrier_stage", get_stage(sel), s);
            end
            set_sd(sel, 1'b1);
            tick();
            set_sd(sel, 1'b0);
            if (s < total - 1) begin
                chk("next_valid", get_valid(sel), 32'(1));
                chk("next_stage", get_stage(sel), s + 1);
            end else begin
                chk("done_pulse", get_done(sel), 32'(1));
                chk("busy_drop", get_busy(sel), 32'(0));
            end
        end
    endtask

    initial begin
        int i;
        int busy0;
        rst = 1'b1;
        s_start = 1'b0; s_sd = 1'b0; s_ready = 1'b0;
        b_start = 1'b0; b_sd = 1'b0; b_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(s_valid), 32'(0));
        chk("rst_idx", 32'({s_a, s_b, s_tw, s_stage}), 32'(0));
        chk("rst_last", 32'(s_last), 32'(0));
        chk("rst_busy", 32'(s_busy), 32'(0));
        chk("rst_done", 32'(s_done), 32'(0));
        chk("rst_big", 32'({b_valid, b_busy, b_done, b_a, b_tw}), 32'(0));
        rst = 1'b0;
        tick();

        // Nominal 8-point run with ready held high
        push_small();
        s_ready = 1'b1;
        busy0 = s_busy_cyc;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("start_lat_valid", 32'(s_valid), 32'(1));
        chk("start_lat_busy", 32'(s_busy), 32'(1));
        run_stages(0, 3, 3, 0, 200);
        tick();
        chk("done_one_cycle", 32'(s_done), 32'(0));
        chk("A_q_empty", 32'(q_s.size()), 32'(0));
        chk("A_done_cnt", 32'(s_done_cnt), 32'(1));
        chk("A_busy_cycles", 32'(s_busy_cyc - busy0), 32'(15));

        // Random backpressure
        push_small();
        bp_en = 1'b1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        run_stages(0, 3, 3, 0, 400);
        bp_en = 1'b0;
        s_ready = 1'b1;
        tick();
        chk("B_q_empty", 32'(q_s.size()), 32'(0));
        chk("B_done_cnt", 32'(s_done_cnt), 32'(2));

        // stage_done during ISSUE is ignored; barrier held 20 cycles
        push_small();
        s_ready = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_sd = 1'b1;
        tick();
        s_sd = 1'b0;
        tick();
        chk("C_issue_valid", 32'(s_valid), 32'(1));
        chk("C_issue_stage", 32'(s_stage), 32'(0));
        chk("C_issue_a", 32'(s_a), 32'(0));
        s_ready = 1'b1;
        run_stages(0, 3, 3, 20, 200);
        tick();
        chk("C_q_empty", 32'(q_s.size()), 32'(0));
        chk("C_done_cnt", 32'(s_done_cnt), 32'(3));

        // Reset while stage 1 presents c=2
        for (int j = 0; j < 6; j++) begin
            desc_t d;
            push_small();
            d = q_s[q_s.size() - 12 + j];
            if (j == 5) begin
                while (q_s.size() > 0) void'(q_s.pop_back());
            end
        end
        // Rebuild exactly the six descriptors expected before the reset
        push_small();
        while (q_s.size() > 6) void'(q_s.pop_back());
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        run_stages(0, 1, 3, 0, 200);
        i = 0;
        while (!(s_stage == 2'd1 && s_a == 3'd4) && i < 20) begin
            tick();
            i++;
        end
        chk("D_reached_c2", 32'(i < 20), 32'(1));
        rst = 1'b1;
        #1;
        chk("D_async_valid", 32'(s_valid), 32'(0));
        chk("D_async_idx", 32'({s_a, s_b, s_tw, s_stage}), 32'(0));
        chk("D_async_last", 32'(s_last), 32'(0));
        chk("D_async_busy", 32'(s_busy), 32'(0));
        tick();
        rst = 1'b0;
        tick();
        chk("D_no_done", 32'(s_done_cnt), 32'(3));
        chk("D_q_empty", 32'(q_s.size()), 32'(0));
        push_small();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("D_restart", 32'({s_valid, s_a, s_b, s_tw, s_stage}), 32'({1'b1, 3'd0, 3'd1, 12'd0, 2'd0}));
        run_stages(0, 3, 3, 0, 200);
        tick();
        chk("D_q_empty2", 32'(q_s.size()), 32'(0));
        chk("D_done_cnt", 32'(s_done_cnt), 32'(4));

        // start held high: no restart while busy, new run right after done
        push_small();
        push_small();
        s_start = 1'b1;
        tick();
        run_stages(0, 3, 3, 0, 200);
        tick();
        chk("E_restart_valid", 32'(s_valid), 32'(1));
        chk("E_restart_busy", 32'(s_busy), 32'(1));
        chk("E_restart_done", 32'(s_done), 32'(0));
        chk("E_restart_stage", 32'(s_stage), 32'(0));
        s_start = 1'b0;
        run_stages(0, 3, 3, 0, 200);
        tick();
        chk("E_q_empty", 32'(q_s.size()), 32'(0));
        chk("E_done_cnt", 32'(s_done_cnt), 32'(6));

        // Full 4096-point transform
        push_big();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        run_stages(1, 12, 12, 0, 5000);
        tick();
        chk("F_q_empty", 32'(q_b.size()), 32'(0));
        chk("F_done_cnt", 32'(b_done_cnt), 32'(1));
        chk("F_final_a", 32'(b_last_a), 32'(2047));
        chk("F_final_b", 32'(b_last_b), 32'(4095));
        chk("F_final_tw", 32'(b_last_tw), 32'(2047));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
